// File: rtl/div_unit.sv
`default_nettype none
// ===========================================================================
// div_unit : iterative radix-2 DIV/DIVU divider, stalls EX while in flight.
// Optional: define DIV_EARLY_OUT_EN to finish at once when |dividend|<|divisor|.
// Revision : 1.0
// ===========================================================================
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             stall_for_ex,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, lo_q, hi_q;
  logic             qneg_q, rneg_q;

  logic             accept, divz, early, ge, fire;
  logic [WIDTH-1:0] a_abs, b_abs, rem_sub, lo_fix, hi_fix;
  logic [WIDTH:0]   rem_sh;

  assign accept = (state_q == S_IDLE) && div_start && !cancel;
  assign a_abs  = (div_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign b_abs  = (div_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign divz   = (divisor == '0);
`ifdef DIV_EARLY_OUT_EN
  assign early  = !divz && (a_abs < b_abs);
`else
  assign early  = 1'b0;
`endif

  // Shifted remainder needs one extra bit: it can reach 2*divisor-1.
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign ge      = (rem_sh >= {1'b0, dvs_q});
  assign rem_sub = rem_sh[WIDTH-1:0] - dvs_q;

  assign lo_fix = qneg_q ? -quo_q : quo_q;
  assign hi_fix = rneg_q ? -rem_q : rem_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (divz || early) ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (cancel) state_d = S_IDLE;
  end

  always_comb begin
    stall_for_ex = 1'b0;
    busy         = 1'b0;
    fire         = 1'b0;
    case (state_q)
      S_IDLE: stall_for_ex = div_start && !cancel && resetn;
      S_BUSY: begin
        stall_for_ex = !cancel && resetn;
        busy         = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        fire = !cancel;
      end
      default: ;
    endcase
  end

  assign result_valid = fire;
  assign result_lo    = fire ? lo_fix : lo_q;
  assign result_hi    = fire ? hi_fix : hi_q;

  // Divide-by-zero and early-out reuse the DONE sign fix-up by parking the
  // magnitude of the dividend in the remainder register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      if (accept) begin
        dvs_q  <= b_abs;
        cnt_q  <= CNT_W'(WIDTH);
        rneg_q <= div_signed && dividend[WIDTH-1];
        qneg_q <= div_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        if (divz) begin
          rem_q  <= a_abs;
          quo_q  <= '1;
          qneg_q <= 1'b0;
        end else if (early) begin
          rem_q <= a_abs;
          quo_q <= '0;
        end else begin
          rem_q <= '0;
          quo_q <= a_abs;
        end
      end else if (state_q == S_BUSY && !cancel) begin
        rem_q <= ge ? rem_sub : rem_sh[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], ge};
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (fire) begin
        lo_q <= lo_fix;
        hi_q <= hi_fix;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ===========================================================================
// tb_div_unit : vector table + scoreboard bench for div_unit.
// Revision : 1.0
// ===========================================================================
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif
  localparam int NVEC = 12;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn, div_start, div_signed, cancel;
  logic [31:0] dividend, divisor;
  logic        stall_for_ex, busy, result_valid;
  logic [31:0] result_lo, result_hi;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   done_cyc;
  exp_t sb_q[$];
  vec_t vec[NVEC];

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .div_start    (div_start),
    .div_signed   (div_signed),
    .dividend     (dividend),
    .divisor      (divisor),
    .cancel       (cancel),
    .stall_for_ex (stall_for_ex),
    .busy         (busy),
    .result_valid (result_valid),
    .result_lo    (result_lo),
    .result_hi    (result_hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard: every result_valid pulse must match the oldest queued entry.
  always @(negedge clk) begin
    if (resetn === 1'b1 && result_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got lo=%h hi=%h expected no pulse", result_lo, result_hi);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result_lo", result_lo, e.lo);
        check("result_hi", result_hi, e.hi);
      end
    end
  end

  task automatic run_div(input vec_t v, input bit keep);
    int k;
    int stalls;
    bit got;
    bit st_done;
    exp_t e;
    @(posedge clk); #1;
    div_start  = 1'b1;
    div_signed = v.sgn;
    dividend   = v.a;
    divisor    = v.b;
    e.lo = v.lo;
    e.hi = v.hi;
    sb_q.push_back(e);
    k = 0; stalls = 0; got = 1'b0; st_done = 1'b1;
    while (!got && k < 100) begin
      @(negedge clk);
      if (result_valid) begin
        got     = 1'b1;
        st_done = stall_for_ex;
      end else begin
        if (stall_for_ex) stalls++;
        k++;
        @(posedge clk); #1;
      end
    end
    check("latency", k, v.lat);
    check("stall_cycles", stalls, v.lat);
    check("stall_at_done", {31'd0, st_done}, 32'd0);
    done_cyc = cyc;
    if (!keep) begin
      @(posedge clk); #1;
      div_start = 1'b0;
    end
  endtask

  task automatic start_raw(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    div_start  = 1'b1;
    div_signed = 1'b0;
    dividend   = a;
    divisor    = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c1;
    vec[0]  = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        33};
    vec[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};
    vec[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        33};
    vec[3]  = '{1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'd5,        1};
    vec[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        33};
    vec[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF, 32'd0,        33};
    vec[6]  = '{1'b1, 32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFF9, 1};
    vec[7]  = '{1'b0, 32'd3,          32'd10,       32'd0,        32'd3,        EARLY_LAT};
    vec[8]  = '{1'b1, 32'hFFFF_FFFD,  32'd10,       32'd0,        32'hFFFF_FFFD, EARLY_LAT};
    vec[9]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,        32'd0,        33};
    vec[10] = '{1'b0, 32'h8000_0000,  32'd3,        32'h2AAA_AAAA, 32'd2,        33};
    vec[11] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,       32'hFFFF_FFFE, 33};

    resetn = 1'b0; div_start = 1'b0; div_signed = 1'b0; cancel = 1'b0;
    dividend = '0; divisor = '0;
    #1;
    check("rst_stall", {31'd0, stall_for_ex}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_lo", result_lo, 32'd0);
    check("rst_hi", result_hi, 32'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) run_div(vec[i], 1'b0);

    // Back-to-back: second accept right after DONE, pulses 34 cycles apart.
    run_div('{1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 33}, 1'b1);
    c1 = done_cyc;
    run_div('{1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 33}, 1'b0);
    check("b2b_spacing", done_cyc - c1, 34);

    // Cancel in BUSY at T+10: no pulse, previous hi/lo (3/2) retained.
    start_raw(32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #1 cancel = 1'b1;
    @(negedge clk);
    check("cancel_stall", {31'd0, stall_for_ex}, 32'd0);
    check("cancel_valid", {31'd0, result_valid}, 32'd0);
    @(posedge clk); #1;
    cancel = 1'b0; div_start = 1'b0;
    @(negedge clk);
    check("cancel_busy", {31'd0, busy}, 32'd0);
    check("cancel_lo", result_lo, 32'd3);
    check("cancel_hi", result_hi, 32'd2);
    repeat (40) @(posedge clk);

    // Cancel wins over accept in IDLE.
    @(posedge clk); #1;
    div_start = 1'b1; cancel = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(negedge clk);
    check("cancel_accept_stall", {31'd0, stall_for_ex}, 32'd0);
    @(posedge clk); #1;
    div_start = 1'b0; cancel = 1'b0;
    @(negedge clk);
    check("cancel_accept_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset 15 cycles into a divide.
    start_raw(32'd50, 32'd5);
    repeat (15) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_stall", {31'd0, stall_for_ex}, 32'd0);
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, result_valid}, 32'd0);
    check("midrst_lo", result_lo, 32'd0);
    check("midrst_hi", result_hi, 32'd0);
    @(posedge clk); #1 div_start = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    run_div('{1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33}, 1'b0);

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 divider in the EX stage for MIPS DIV and DIVU.
- Raises stall_for_ex toward the pipeline control block while a divide is in flight; control responds with stall vector 6'b00_1111, holding PC, IF, ID and EX.
- Delivers the quotient (LO) and remainder (HI) to EX/MEM in the cycle the stall drops.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  pipeline clock
- resetn  input  1  asynchronous active-low reset
- div_start  input  1  EX holds a valid DIV/DIVU; stays high while EX is stalled
- div_signed  input  1  1 = DIV, 0 = DIVU; sampled at accept
- dividend  input  WIDTH  rs value; sampled at accept
- divisor  input  WIDTH  rt value; sampled at accept
- cancel  input  1  pipeline flush; aborts any operation
- stall_for_ex  output  1  stall request to the control block
- busy  output  1  unit not in IDLE
- result_valid  output  1  one-cycle pulse; hi/lo valid
- result_lo  output  WIDTH  quotient
- result_hi  output  WIDTH  remainder

Behaviour:
- Reset (resetn low, asynchronous): state IDLE, counter 0, all outputs 0.
- States are IDLE, BUSY and DONE.
- IDLE:
  - div_start=1 and cancel=0 is an accept.
  - At accept: latch abs(dividend) and abs(divisor) (raw values when div_signed=0), the sign of the quotient (dividend[31]^divisor[31]) and the sign of the remainder (dividend[31]). Clear the 64-bit partial remainder and set counter=WIDTH.
  - Go to BUSY, or to DONE if divisor==0.
- stall_for_ex is combinational:
  - high in IDLE while div_start=1 and cancel=0;
  - high throughout BUSY;
  - low in DONE and in every cycle where cancel=1.
- BUSY, one quotient bit per cycle:
  - Shift {rem,quo} left by 1.
  - If rem >= divisor: rem -= divisor and set quo[0]=1.
  - Decrement the counter; at counter==1 go to DONE.
- DONE:
  - Apply the latched signs: negate quotient if its sign bit is set, negate remainder if the dividend was negative.
  - Drive result_lo/result_hi and pulse result_valid=1 for exactly one cycle.
  - Next state is IDLE.
  - div_start is ignored this cycle; it is still high because EX has not yet advanced.
- Results hold their value after DONE until the next DONE.
- Latency: accept at cycle T, result_valid at T+WIDTH+1 (T+33). stall_for_ex is high for 33 cycles (T..T+32).
- Divide by zero: DONE at T+1, result_lo=32'hFFFF_FFFF, result_hi=dividend (raw). stall_for_ex is high for 1 cycle.
- Overflow, DIV 32'h8000_0000 / 32'hFFFF_FFFF: result_lo=32'h8000_0000, result_hi=0 (natural wrap), no exception.
- cancel=1 in any state:
  - next state is IDLE and result_valid is not asserted;
  - hi/lo are unchanged;
  - cancel takes priority over accept in the same cycle.
- Back-to-back divides: after DONE→IDLE, a new div_start is accepted in the next cycle. There are no bubbles beyond the DONE cycle.
- Reset mid-operation: immediate IDLE, stall_for_ex=0, result_valid=0.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- When defined: at accept, if abs(dividend) < abs(divisor) and divisor!=0, go directly to DONE. Quotient is 0 and the remainder is the dividend, sign-corrected; latency is T+1 with stall_for_ex high 1 cycle.
- When undefined: every nonzero-divisor divide takes the full 33 cycles, giving deterministic latency.

Test Plan:
- DIVU 100/7, div_start held high → stall_for_ex high for 33 cycles; result_valid at T+33 with lo=14, hi=2; stall low in the same cycle.
- DIV -7/2 (32'hFFFF_FFF9 / 2) → lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1); DIV 7/-2 → lo=-3, hi=1.
- DIVU 5/0 → result_valid at T+1, lo=32'hFFFF_FFFF, hi=5; DIV 32'h8000_0000 / -1 → lo=32'h8000_0000, hi=0.
- Cancel during BUSY at T+10 → IDLE next cycle, stall_for_ex=0 while cancel is high, no result_valid pulse, hi/lo retain their previous values.
- resetn low at T+15 of a divide → all outputs 0 asynchronously; after release, a new DIVU 9/3 gives lo=3, hi=0.
- Two consecutive DIVUs (10/3, then 20/6) → two result_valid pulses 34 cycles apart with lo=3/hi=1, then lo=3/hi=2. With DIV_EARLY_OUT_EN, DIVU 3/10 → valid at T+1, lo=0, hi=3.
